led_scene_scheduler: RTL

//  Sequences the 4-bit LED bank through a fixed table of patterns. Each pattern

---
 rtl/led_sched_pkg.sv | 25 ++
 rtl/led_dwell_timer.sv | 54 +++++
 rtl/led_scene_scheduler.sv | 119 +++++++++++
 3 files changed

// File: rtl/led_sched_pkg.sv
// ============================================================================
// led_sched_pkg : shared state encoding, LED pattern table, default timing
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package led_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int unsigned T_FAST_DEF  = 50_000_000;
  localparam int unsigned T_SLOW_DEF  = 500_000_000;
  localparam int unsigned CTR_W_DEF   = 32;
  localparam int unsigned N_STEPS_DEF = 6;

  // Element 0 is rightmost; unused slots 6..7 drive all LEDs off.
  localparam logic [7:0][3:0] LED_TABLE = {4'hF, 4'hF, 4'hA, 4'h5, 4'hF, 4'h3, 4'h0, 4'hC};

endpackage

`default_nettype wire

// File: rtl/led_dwell_timer.sv
// ============================================================================
// led_dwell_timer : dwell counter with mode-selected terminal count
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module led_dwell_timer
  import led_sched_pkg::*;
#(
  parameter int unsigned T_FAST = T_FAST_DEF,
  parameter int unsigned T_SLOW = T_SLOW_DEF,
  parameter int unsigned CTR_W  = CTR_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic mode,
  output logic tc
);

  localparam logic [CTR_W-1:0] LAST_FAST = CTR_W'(T_FAST - 1);
  localparam logic [CTR_W-1:0] LAST_SLOW = CTR_W'(T_SLOW - 1);

  logic [CTR_W-1:0] ctr_q;
  logic [CTR_W-1:0] ctr_d;
  logic [CTR_W-1:0] last_cnt;

  always_comb begin
    last_cnt = mode ? LAST_SLOW : LAST_FAST;
    tc       = (ctr_q == last_cnt);
  end

  // Clear beats enable so a mode toggle or manual step always restarts the dwell.
  always_comb begin
    ctr_d = ctr_q;
    if (clr) begin
      ctr_d = '0;
    end else if (en) begin
      ctr_d = tc ? '0 : ctr_q + CTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_scene_scheduler.sv
// ============================================================================
// led_scene_scheduler : steps the LED bank through a pattern table with
//                       run/pause, single-step and fast/slow dwell control
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module led_scene_scheduler
  import led_sched_pkg::*;
#(
  parameter int unsigned T_FAST  = T_FAST_DEF,
  parameter int unsigned T_SLOW  = T_SLOW_DEF,
  parameter int unsigned N_STEPS = N_STEPS_DEF,
  parameter int unsigned CTR_W   = CTR_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_run,
  input  logic       key_step,
  input  logic       key_mode,
  output logic [3:0] led,
  output logic       running,
  output logic [2:0] step_idx,
  output logic       mode
);

  localparam logic [2:0] LAST_STEP = 3'(N_STEPS - 1);

  state_e     state_q, state_d;
  logic [2:0] step_idx_q, step_idx_d;
  logic       mode_q, mode_d;
  logic       tmr_en, tmr_clr, tmr_tc;
  logic       advance;

  led_dwell_timer #(
    .T_FAST (T_FAST),
    .T_SLOW (T_SLOW),
    .CTR_W  (CTR_W)
  ) u_dwell_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (tmr_en),
    .clr  (tmr_clr),
    .mode (mode_q),
    .tc   (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      step_idx_q <= 3'd0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_idx_q <= step_idx_d;
      mode_q     <= mode_d;
    end
  end

  // Key priority mode > run > step; a losing key or a dropped tc has no effect.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    tmr_en     = 1'b0;
    tmr_clr    = 1'b0;
    advance    = 1'b0;
    step_idx_d = step_idx_q;
    if (key_mode) begin
      mode_d  = ~mode_q;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tmr_clr = 1'b1;
          if (key_run) begin
            state_d    = ST_RUN;
            step_idx_d = 3'd0;
          end
        end
        ST_RUN: begin
          if (key_run) begin
            state_d = ST_PAUSE;
          end else if (key_step) begin
            advance = 1'b1;
            tmr_clr = 1'b1;
          end else begin
            tmr_en  = 1'b1;
            advance = tmr_tc;
          end
        end
        ST_PAUSE: begin
          if (key_run) begin
            state_d = ST_RUN;
          end else if (key_step) begin
            advance = 1'b1;
            tmr_clr = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tmr_clr = 1'b1;
        end
      endcase
    end
    if (advance) begin
      step_idx_d = (step_idx_q == LAST_STEP) ? 3'd0 : step_idx_q + 3'd1;
    end
  end

  always_comb begin
    running  = (state_q == ST_RUN);
    led      = (state_q == ST_IDLE) ? 4'hF : LED_TABLE[step_idx_q];
    step_idx = step_idx_q;
    mode     = mode_q;
  end

endmodule

`default_nettype wire
